// File: rtl/alu_seq.sv
// Registered SAP-style ALU: single-edge arithmetic/logic/shift ops plus an
// iterative shift-add multiply, with a done pulse and a tri-state bus driver.
module alu_seq #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] reb,
  input  logic             eu,
  output logic [WIDTH-1:0] bus,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0, OP_SUB = 4'd1, OP_ADC = 4'd2, OP_SBB = 4'd3,
    OP_AND = 4'd4, OP_OR  = 4'd5, OP_XOR = 4'd6, OP_NOT = 4'd7,
    OP_SHL = 4'd8, OP_SHR = 4'd9, OP_MUL = 4'd10
  } op_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [3:0]         flags_q, flags_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     ext;
  logic               alu_v;
  logic               alu_ok;
  logic [2*WIDTH-1:0] prod_step;
  logic               a_msb, b_msb, r_msb;

  assign a_msb = acc[WIDTH-1];
  assign b_msb = reb[WIDTH-1];
  assign r_msb = ext[WIDTH-1];

  // ext[WIDTH] is the carry/borrow for every single-edge op, including shifts.
  always_comb begin
    ext    = '0;
    alu_v  = 1'b0;
    alu_ok = 1'b1;
    case (op)
      OP_ADD: begin
        ext   = {1'b0, acc} + {1'b0, reb};
        alu_v = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_ADC: begin
        ext   = {1'b0, acc} + {1'b0, reb} + {{WIDTH{1'b0}}, flags_q[0]};
        alu_v = (a_msb == b_msb) && (r_msb != a_msb);
      end
      OP_SUB: begin
        ext   = {1'b0, acc} - {1'b0, reb};
        alu_v = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_SBB: begin
        ext   = {1'b0, acc} - {1'b0, reb} - {{WIDTH{1'b0}}, flags_q[0]};
        alu_v = (a_msb != b_msb) && (r_msb != a_msb);
      end
      OP_AND:  ext = {1'b0, acc & reb};
      OP_OR:   ext = {1'b0, acc | reb};
      OP_XOR:  ext = {1'b0, acc ^ reb};
      OP_NOT:  ext = {1'b0, ~acc};
      OP_SHL:  ext = {acc, 1'b0};
      OP_SHR:  ext = {acc[0], 1'b0, acc[WIDTH-1:1]};
      default: alu_ok = 1'b0;
    endcase
  end

  assign prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    hi_d     = hi_q;
    flags_d  = flags_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    case (state_q)
      S_MUL: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d  = S_DONE;
          result_d = prod_step[WIDTH-1:0];
          hi_d     = prod_step[2*WIDTH-1:WIDTH];
          flags_d  = {(prod_step[2*WIDTH-1:WIDTH] != '0),
                      prod_step[WIDTH-1],
                      (prod_step[WIDTH-1:0] == '0),
                      (prod_step[2*WIDTH-1:WIDTH] != '0)};
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            cnt_d    = '0;
            prod_d   = '0;
            mcand_d  = {{WIDTH{1'b0}}, acc};
            mplier_d = reb;
          end else begin
            state_d = S_DONE;
            if (alu_ok) begin
              result_d = ext[WIDTH-1:0];
              hi_d     = '0;
              flags_d  = {alu_v, r_msb, (ext[WIDTH-1:0] == '0), ext[WIDTH]};
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      hi_q     <= '0;
      flags_q  <= '0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      hi_q     <= hi_d;
      flags_q  <= flags_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign bus       = eu ? result_q : 'z;
  assign result_hi = hi_q;
  assign flags     = flags_q;
  assign busy      = (state_q == S_MUL);
  assign done      = (state_q == S_DONE);

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the SAP accumulator/B-register ALU.
- Takes acc and reb operands with an opcode and executes on a start pulse.
- Holds the result and a flags register, and drives the result onto the shared tri-state bus when eu is high.
- Adds logic ops, shifts, carry-chained add/sub, and an iterative multi-cycle multiply with a busy/done handshake.

Parameters:
- WIDTH, 8: operand, result and bus width in bits (≥4).
- CNT_W, $clog2(WIDTH)+1: multiply iteration counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  operation request, sampled on rising clk.
- op  input  4  opcode. 0 ADD, 1 SUB, 2 ADC, 3 SBB, 4 AND, 5 OR, 6 XOR, 7 NOT(acc), 8 SHL(acc), 9 SHR(acc), 10 MUL. 11-15 are NOP.
- acc  input  WIDTH  operand A.
- reb  input  WIDTH  operand B.
- eu  input  1  bus output enable.
- bus  output  WIDTH  result when eu=1, else high-Z.
- result_hi  output  WIDTH  upper half of the MUL product. Otherwise 0.
- flags  output  4  registered {V,N,Z,C}.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - result, result_hi, flags, counter and done are cleared to 0; busy=0.
  - bus is high-Z unless eu=1, in which case it drives 0.
- States: IDLE, MUL, DONE.
- Operand capture: acc, reb and op are latched at the start edge. Later operand changes have no effect on an operation in flight.
- IDLE with start=1 and op≠MUL:
  - At the same edge, result (low WIDTH bits) and flags are written, and the FSM goes to DONE.
  - done=1 for exactly the following cycle, then the FSM returns to IDLE.
  - Latency: 1 edge.
  - start is accepted again in the DONE cycle (back-to-back ops allowed).
- IDLE with start=1 and op=MUL:
  - Go to MUL with busy=1 and counter=0.
  - Each edge performs one shift-add step on a 2·WIDTH product.
  - After WIDTH steps: go to DONE and write result=product[WIDTH-1:0], result_hi=product[2W-1:W].
  - busy drops in the DONE cycle. Latency: WIDTH+1 edges from start to done.
  - start during MUL is ignored and not queued.
- Arithmetic, computed at WIDTH+1 bits:
  - ADD: C = carry out.
  - SUB: computes acc−reb; C=1 means borrow.
  - ADC adds the stored C; SBB subtracts the stored C.
  - V = signed overflow for add/sub, and 0 otherwise.
- Logic and shifts:
  - AND/OR/XOR/NOT: C=0, V=0.
  - SHL: C = acc[W-1], zero filled.
  - SHR: logical; C = acc[0].
- Z, N and result_hi:
  - Z = (result==0), computed on the low half for MUL.
  - N = result MSB.
  - For MUL, C=V=(result_hi≠0).
  - Non-MUL ops clear result_hi.
- NOP opcodes: done pulses after 1 edge; result, result_hi and flags are unchanged.
- Flags and result update only at completion; they hold between operations.
- bus is combinational from the result register and eu only. It is independent of busy, so it shows the previous result during a MUL.
- Reset asserted mid-MUL aborts immediately to reset values. No done pulse is produced.
- start and reset deasserting at the same edge: start is ignored for that edge.

Test Plan (WIDTH=8):
- Reset, then eu=0 → bus=8'hZZ. With eu=1 → bus=8'h00, flags=4'b0000, busy=0.
- ADD acc=8'h33, reb=8'hAA, eu=1 → after 1 edge bus=8'hDD, flags {V,N,Z,C}=4'b0100, done high exactly 1 cycle.
- SUB acc=8'h69, reb=8'hBB → result=8'hAE, flags=4'b1101. Then ADC acc=8'h01, reb=8'h01 → result=8'h03 (stored C=1).
- MUL acc=8'hFF, reb=8'hFF → busy high 8 cycles, done on edge 9, result=8'h01, result_hi=8'hFE, flags=4'b1001. A start pulse mid-MUL leaves the outcome unchanged.
- SHL acc=8'h81 → result=8'h02, C=1. Next, SHR acc=8'h01 → result=8'h00, flags=4'b0011.
- Start MUL, assert rst_n=0 at cycle 4 → busy=0, result=0, result_hi=0, no done pulse. After release, ADD 8'h01+8'h01 → result=8'h02.
